cache_control_nway: RTL and testbench

Parametrised write-back, write-allocate controller for an N-way set-associative cache; next generation of the 4-way L2 controller. Adds an arbitrary power-of-two way count with tree pseudo-LRU, invalid-way-first allocation, a whole-cache flush walk, and saturating hit/miss counters. Sits between the cacheline adaptor (mem side) and the requesting cache level (cpu side), driving the tag/data/valid/dirty/LRU arrays of the datapath.

---
 rtl/cache_control_nway.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_control_nway.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_nway.sv
// Write-back / write-allocate controller for an N-way set-associative cache with tree
// pseudo-LRU replacement, invalid-way-first allocation, whole-cache flush and hit/miss counters.
module cache_control_nway #(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 16,
    parameter  int CNT_W = 32,
    localparam int LW    = $clog2(WAYS),
    localparam int SW    = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_read,
    input  logic             cpu_write,
    output logic             cache_resp,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_resp,
    input  logic [WAYS-1:0]  hit,
    input  logic [WAYS-1:0]  valid_o,
    input  logic [WAYS-1:0]  dirty_o,
    input  logic [WAYS-2:0]  lru_o,
    output logic [WAYS-2:0]  lru_i,
    output logic             load_lru,
    output logic [LW-1:0]    way_sel,
    output logic [WAYS-1:0]  load_tag,
    output logic [WAYS-1:0]  write_en,
    output logic             data_i_sel,
    output logic [WAYS-1:0]  dirty_i,
    output logic [WAYS-1:0]  valid_i,
    output logic             load_dirty,
    output logic             load_valid,
    output logic             mm_address_sel,
    input  logic             flush_req,
    output logic             flush_active,
    output logic [SW-1:0]    flush_set,
    output logic             flush_done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [2:0] {IDLE, SEARCH, WRITE_BACK, NEW_BLOCK, FL_CHECK, FL_WB} state_t;

    state_t           r_state;
    logic [LW-1:0]    r_victim;
    logic [SW+LW-1:0] r_flushPos;
    logic             r_refill;
    logic [CNT_W-1:0] r_hitCount;
    logic [CNT_W-1:0] r_missCount;

    logic             w_hitAny;
    logic [LW-1:0]    w_hitWay;
    logic [LW-1:0]    w_missVictim;
    logic [LW-1:0]    w_flushWay;
    logic [WAYS-1:0]  w_hitMask;
    logic [WAYS-1:0]  w_victimMask;
    logic [WAYS-1:0]  w_flushMask;
    logic             w_flushLast;
    logic             w_flushLineDirty;

    function automatic logic [LW-1:0] lowestIdx(input logic [WAYS-1:0] vec);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (vec[i]) idx = LW'(i);
        return idx;
    endfunction

    // The tree is padded to 2*WAYS entries so a node index of LW+1 bits addresses it exactly.
    function automatic logic [LW-1:0] plruVictim(input logic [WAYS-2:0] tree);
        logic [2*WAYS-1:0] ext;
        logic [LW:0]       node;
        ext  = {(WAYS+1)'(0), tree};
        node = '0;
        for (int l = 0; l < LW; l++)
            node = {node[LW-1:0], 1'b1} + {{LW{1'b0}}, ext[node]};
        return LW'(node - (LW+1)'(WAYS - 1));
    endfunction

    function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] tree, input logic [LW-1:0] way);
        logic [2*WAYS-1:0] ext;
        logic [LW:0]       node;
        logic [LW-1:0]     wv;
        logic              dir;
        ext  = {(WAYS+1)'(0), tree};
        node = '0;
        wv   = way;
        for (int l = 0; l < LW; l++) begin
            dir       = wv[LW-1];
            wv        = wv << 1;
            ext[node] = ~dir;
            node      = {node[LW-1:0], 1'b1} + {{LW{1'b0}}, dir};
        end
        return ext[WAYS-2:0];
    endfunction

    assign w_hitAny         = |hit;
    assign w_hitWay         = lowestIdx(hit);
    assign w_missVictim     = (&valid_o) ? plruVictim(lru_o) : lowestIdx(~valid_o);
    assign w_flushWay       = r_flushPos[LW-1:0];
    assign w_hitMask        = WAYS'(1) << w_hitWay;
    assign w_victimMask     = WAYS'(1) << r_victim;
    assign w_flushMask      = WAYS'(1) << w_flushWay;
    assign w_flushLast      = &r_flushPos;
    assign w_flushLineDirty = valid_o[w_flushWay] & dirty_o[w_flushWay];
    assign flush_set        = r_flushPos[SW+LW-1:LW];
    assign hit_count        = r_hitCount;
    assign miss_count       = r_missCount;

    // Flush position is {set, way}; a plain increment walks way-fastest and wraps to (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_victim    <= '0;
            r_flushPos  <= '0;
            r_refill    <= 1'b0;
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_req)
                        r_state <= FL_CHECK;
                    else if (cpu_read || cpu_write)
                        r_state <= SEARCH;
                end
                SEARCH: begin
                    if (w_hitAny) begin
                        r_state  <= IDLE;
                        r_refill <= 1'b0;
                        if (!r_refill && (r_hitCount != '1))
                            r_hitCount <= r_hitCount + 1'b1;
                    end else begin
                        r_victim <= w_missVictim;
                        if (r_missCount != '1)
                            r_missCount <= r_missCount + 1'b1;
                        r_state <= (valid_o[w_missVictim] && dirty_o[w_missVictim]) ? WRITE_BACK : NEW_BLOCK;
                    end
                end
                WRITE_BACK: if (mem_resp) r_state <= NEW_BLOCK;
                NEW_BLOCK: begin
                    if (mem_resp) begin
                        r_state  <= SEARCH;
                        r_refill <= 1'b1;
                    end
                end
                FL_CHECK: begin
                    if (w_flushLineDirty) begin
                        r_state <= FL_WB;
                    end else begin
                        r_flushPos <= r_flushPos + 1'b1;
                        r_state    <= w_flushLast ? IDLE : FL_CHECK;
                    end
                end
                FL_WB: begin
                    if (mem_resp) begin
                        r_flushPos <= r_flushPos + 1'b1;
                        r_state    <= w_flushLast ? IDLE : FL_CHECK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cache_resp     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        lru_i          = lru_o;
        load_lru       = 1'b0;
        way_sel        = r_victim;
        load_tag       = '0;
        write_en       = '0;
        data_i_sel     = 1'b0;
        dirty_i        = dirty_o;
        valid_i        = valid_o;
        load_dirty     = 1'b0;
        load_valid     = 1'b0;
        mm_address_sel = 1'b0;
        flush_active   = 1'b0;
        flush_done     = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_hitAny) begin
                    way_sel    = w_hitWay;
                    lru_i      = plruTouch(lru_o, w_hitWay);
                    load_lru   = 1'b1;
                    cache_resp = 1'b1;
                    if (cpu_write) begin
                        write_en   = w_hitMask;
                        dirty_i    = dirty_o | w_hitMask;
                        load_dirty = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                mem_write      = 1'b1;
                mm_address_sel = 1'b1;
            end
            NEW_BLOCK: begin
                mem_read   = 1'b1;
                write_en   = w_victimMask;
                load_tag   = w_victimMask;
                data_i_sel = 1'b1;
                valid_i    = valid_o | w_victimMask;
                dirty_i    = dirty_o & ~w_victimMask;
                load_valid = 1'b1;
                load_dirty = 1'b1;
            end
            FL_CHECK: begin
                flush_active = 1'b1;
                flush_done   = w_flushLast & ~w_flushLineDirty;
            end
            FL_WB: begin
                flush_active   = 1'b1;
                mem_write      = 1'b1;
                mm_address_sel = 1'b1;
                way_sel        = w_flushWay;
                if (mem_resp) begin
                    dirty_i    = dirty_o & ~w_flushMask;
                    load_dirty = 1'b1;
                    flush_done = w_flushLast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// Self-checking bench for cache_control_nway: directed and randomized accesses and flushes
// against a range-splitting PLRU model and per-line dirty/valid maps.
module tb_cache_control_nway;

    localparam int WAYS  = 4;
    localparam int SETS  = 4;
    localparam int CNT_W = 4;
    localparam int LW    = 2;
    localparam int SW    = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_read, cpu_write, mem_resp, flush_req;
    logic [WAYS-1:0]  hit, valid_o, dirty_o;
    logic [WAYS-2:0]  lru_o;
    logic             cache_resp, mem_read, mem_write, load_lru, data_i_sel;
    logic             load_dirty, load_valid, mm_address_sel, flush_active, flush_done;
    logic [WAYS-2:0]  lru_i;
    logic [LW-1:0]    way_sel;
    logic [WAYS-1:0]  load_tag, write_en, dirty_i, valid_i;
    logic [SW-1:0]    flush_set;
    logic [CNT_W-1:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    int expHit, expMiss, lastVictim;
    logic [WAYS-1:0] validMap [SETS];
    logic [WAYS-1:0] dirtyMap [SETS];

    cache_control_nway #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cache_resp(cache_resp), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit(hit), .valid_o(valid_o), .dirty_o(dirty_o),
        .lru_o(lru_o), .lru_i(lru_i), .load_lru(load_lru), .way_sel(way_sel),
        .load_tag(load_tag), .write_en(write_en), .data_i_sel(data_i_sel),
        .dirty_i(dirty_i), .valid_i(valid_i), .load_dirty(load_dirty),
        .load_valid(load_valid), .mm_address_sel(mm_address_sel),
        .flush_req(flush_req), .flush_active(flush_active), .flush_set(flush_set),
        .flush_done(flush_done), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int satInc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int lowestSet(input logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // PLRU modelled as halving the way range: a node bit of 0 keeps the lower half.
    function automatic int plruPick(input logic [WAYS-2:0] t);
        int lo = 0, hi = WAYS, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (t[node]) begin lo = mid; node = 2 * node + 2; end
            else begin hi = mid; node = 2 * node + 1; end
        end
        return lo;
    endfunction

    function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] t, input int w);
        int lo = 0, hi = WAYS, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            t[node] = (w < mid);
            if (w < mid) begin hi = mid; node = 2 * node + 1; end
            else begin lo = mid; node = 2 * node + 2; end
        end
        return t;
    endfunction

    task automatic doReset();
        rst = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; mem_resp = 1'b0; flush_req = 1'b0;
        hit = '0; valid_o = 4'b1010; dirty_o = 4'b0110; lru_o = 3'b101;
        #1;
        checkOutput("rst_mem", {mem_read, mem_write}, 0);
        checkOutput("rst_resp", cache_resp, 0);
        checkOutput("rst_way_sel", way_sel, 0);
        checkOutput("rst_hit_count", hit_count, 0);
        checkOutput("rst_miss_count", miss_count, 0);
        checkOutput("rst_flush", {flush_active, flush_done, flush_set}, 0);
        checkOutput("rst_dirty_i", dirty_i, 4'b0110);
        checkOutput("rst_valid_i", valid_i, 4'b1010);
        checkOutput("rst_lru_i", lru_i, 3'b101);
        checkOutput("rst_loads", {write_en, load_tag, load_lru, load_dirty, load_valid}, 0);
        expHit = 0; expMiss = 0; lastVictim = 0;
        @(negedge clk);
        rst = 1'b1;
        nextCycle();
        #1;
    endtask

    task automatic checkHitCycle(input bit isWrite, input int w, input logic [WAYS-2:0] lruV,
                                 input logic [WAYS-1:0] dirtyV);
        logic [WAYS-1:0] m;
        m = WAYS'(1) << w;
        checkOutput("search_resp", cache_resp, 1);
        checkOutput("search_way_sel", way_sel, w);
        checkOutput("search_load_lru", load_lru, 1);
        checkOutput("search_lru_i", lru_i, plruTouch(lruV, w));
        checkOutput("search_write_en", write_en, isWrite ? m : '0);
        checkOutput("search_dirty_i", dirty_i, isWrite ? (dirtyV | m) : dirtyV);
        checkOutput("search_load_dirty", load_dirty, isWrite);
        checkOutput("search_mem", {mem_read, mem_write}, 0);
    endtask

    // One cpu request from IDLE to the IDLE cycle after cache_resp.
    task automatic applyStimulus(input bit isWrite, input logic [WAYS-1:0] hitV,
                                 input logic [WAYS-1:0] validIn, input logic [WAYS-1:0] dirtyIn,
                                 input logic [WAYS-2:0] lruV, input int wbLat, input int rdLat);
        logic [WAYS-1:0] validV, dirtyV, mask;
        int v;
        validV = validIn;
        dirtyV = dirtyIn;
        nextCycle();
        cpu_read = !isWrite; cpu_write = isWrite;
        hit = hitV; valid_o = validV; dirty_o = dirtyV; lru_o = lruV;
        #1;
        checkOutput("idle_resp", cache_resp, 0);
        checkOutput("idle_way_sel", way_sel, lastVictim);
        nextCycle();
        #1;
        if (hitV != '0) begin
            checkHitCycle(isWrite, lowestSet(hitV), lruV, dirtyV);
            expHit = satInc(expHit);
        end else begin
            v = (validV != '1) ? lowestSet(~validV) : plruPick(lruV);
            mask = WAYS'(1) << v;
            checkOutput("miss_resp", cache_resp, 0);
            checkOutput("miss_load_lru", load_lru, 0);
            checkOutput("miss_mem", {mem_read, mem_write}, 0);
            expMiss = satInc(expMiss);
            lastVictim = v;
            if (validV[v] && dirtyV[v]) begin
                for (int c = 1; c <= wbLat; c++) begin
                    nextCycle();
                    mem_resp = (c == wbLat);
                    #1;
                    checkOutput("wb_mem", {mem_read, mem_write}, 2'b01);
                    checkOutput("wb_addr_sel", mm_address_sel, 1);
                    checkOutput("wb_way_sel", way_sel, v);
                    checkOutput("wb_resp", cache_resp, 0);
                end
            end
            for (int c = 1; c <= rdLat; c++) begin
                nextCycle();
                mem_resp = (c == rdLat);
                #1;
                checkOutput("nb_mem", {mem_read, mem_write}, 2'b10);
                checkOutput("nb_write_en", write_en, mask);
                checkOutput("nb_load_tag", load_tag, mask);
                checkOutput("nb_data_sel", data_i_sel, 1);
                checkOutput("nb_valid_i", valid_i, validV | mask);
                checkOutput("nb_dirty_i", dirty_i, dirtyV & ~mask);
                checkOutput("nb_loads", {load_valid, load_dirty, mm_address_sel}, 3'b110);
                checkOutput("nb_miss_count", miss_count, expMiss);
            end
            nextCycle();
            mem_resp = 1'b0;
            validV = validV | mask;
            dirtyV = dirtyV & ~mask;
            hit = mask; valid_o = validV; dirty_o = dirtyV;
            #1;
            checkHitCycle(isWrite, v, lruV, dirtyV);
        end
        nextCycle();
        cpu_read = 1'b0; cpu_write = 1'b0;
        #1;
        checkOutput("end_resp", cache_resp, 0);
        checkOutput("hit_count", hit_count, expHit);
        checkOutput("miss_count", miss_count, expMiss);
    endtask

    // Whole-cache flush from validMap/dirtyMap; optionally a cpu read waits across it.
    task automatic applyFlush(input bit holdCpu, input int maxLat);
        bit last;
        int lat;
        logic [WAYS-1:0] m;
        nextCycle();
        flush_req = 1'b1;
        if (holdCpu) begin cpu_read = 1'b1; hit = 4'b0001; end
        #1;
        checkOutput("fl_idle_active", flush_active, 0);
        nextCycle();
        flush_req = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_o = validMap[s]; dirty_o = dirtyMap[s];
                #1;
                last = (s == SETS - 1) && (w == WAYS - 1);
                m = WAYS'(1) << w;
                checkOutput("fl_active", flush_active, 1);
                checkOutput("fl_set", flush_set, s);
                checkOutput("fl_resp", cache_resp, 0);
                if (validMap[s][w] && dirtyMap[s][w]) begin
                    checkOutput("fl_chk_done", flush_done, 0);
                    checkOutput("fl_chk_mem", mem_write, 0);
                    lat = $urandom_range(1, maxLat);
                    for (int c = 1; c <= lat; c++) begin
                        nextCycle();
                        mem_resp = (c == lat);
                        #1;
                        checkOutput("fl_wb_mem", {mem_read, mem_write}, 2'b01);
                        checkOutput("fl_wb_addr_sel", mm_address_sel, 1);
                        checkOutput("fl_wb_way_sel", way_sel, w);
                        checkOutput("fl_wb_set", flush_set, s);
                        checkOutput("fl_wb_load_dirty", load_dirty, c == lat);
                        checkOutput("fl_wb_done", flush_done, (c == lat) && last);
                        if (c == lat) checkOutput("fl_wb_dirty_i", dirty_i, dirtyMap[s] & ~m);
                    end
                    dirtyMap[s][w] = 1'b0;
                    nextCycle();
                    mem_resp = 1'b0;
                end else begin
                    checkOutput("fl_chk_done", flush_done, last);
                    checkOutput("fl_chk_mem", mem_write, 0);
                    nextCycle();
                end
            end
        end
        #1;
        checkOutput("fl_end_active", flush_active, 0);
        checkOutput("fl_end_done", flush_done, 0);
        checkOutput("fl_end_set", flush_set, 0);
        checkOutput("fl_end_resp", cache_resp, 0);
        if (holdCpu) begin
            nextCycle();
            #1;
            checkOutput("fl_held_resp", cache_resp, 1);
            checkOutput("fl_held_way_sel", way_sel, 0);
            expHit = satInc(expHit);
            nextCycle();
            cpu_read = 1'b0; hit = '0;
            #1;
            checkOutput("fl_held_hit_count", hit_count, expHit);
        end
    endtask

    task automatic applyMidReset();
        nextCycle();
        cpu_read = 1'b1; hit = '0; valid_o = 4'b0111; dirty_o = '0; lru_o = '0;
        #1;
        nextCycle();
        #1;
        nextCycle();
        #1;
        checkOutput("mr_nb_mem_read", mem_read, 1);
        rst = 1'b0;
        #1;
        checkOutput("mr_mem", {mem_read, mem_write}, 0);
        checkOutput("mr_loads", {write_en, load_tag, load_valid, load_dirty}, 0);
        checkOutput("mr_counts", {hit_count, miss_count}, 0);
        checkOutput("mr_way_sel", way_sel, 0);
        cpu_read = 1'b0;
        expHit = 0; expMiss = 0; lastVictim = 0;
        @(negedge clk);
        rst = 1'b1;
        nextCycle();
        #1;
        checkOutput("mr_idle_mem", {mem_read, mem_write, cache_resp}, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit isW;
        logic [WAYS-1:0] hv, vv, dv;
        logic [WAYS-2:0] lv;

        doReset();
        applyStimulus(1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 1, 1);
        applyStimulus(1'b1, 4'b1010, 4'b1111, 4'b0001, 3'b011, 1, 1);
        applyStimulus(1'b0, 4'b0000, 4'b1011, 4'b1111, 3'b000, 2, 3);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0001, 3'b000, 5, 2);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b1000, 3'b111, 1, 1);
        applyMidReset();

        for (int s = 0; s < SETS; s++) begin validMap[s] = '1; dirtyMap[s] = '0; end
        dirtyMap[1] = 4'b0001;
        dirtyMap[3] = 4'b0010;
        validMap[2] = 4'b1011;
        dirtyMap[2] = 4'b0100;
        applyFlush(1'b1, 3);
        applyFlush(1'b0, 2);

        doReset();
        for (int n = 0; n < 17; n++)
            applyStimulus(1'b0, WAYS'($urandom_range(1, 15)), 4'b1111, WAYS'($urandom),
                          (WAYS-1)'($urandom), 1, 1);
        checkOutput("sat_hit_count", hit_count, 4'hF);

        doReset();
        for (int n = 0; n < 60; n++) begin
            isW = 1'($urandom_range(0, 1));
            hv  = ($urandom_range(0, 1) == 1) ? WAYS'($urandom) : '0;
            vv  = ($urandom_range(0, 1) == 1) ? '1 : WAYS'($urandom);
            dv  = WAYS'($urandom);
            lv  = (WAYS-1)'($urandom);
            applyStimulus(isW, hv, vv, dv, lv, $urandom_range(1, 4), $urandom_range(1, 4));
            if (n == 20 || n == 40) begin
                for (int s = 0; s < SETS; s++) begin
                    validMap[s] = WAYS'($urandom);
                    dirtyMap[s] = WAYS'($urandom);
                end
                applyFlush(n == 40, 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
